// File: rtl/mem_arbiter.sv
// Four-way shared-RAM arbiter: data caches beat instruction caches, with round-robin between cores.
// A single request is granted at a time, and the RAM is driven from the live inputs of the granted cache.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [1:0]  iREN,
    input  logic [31:0] iaddr0,
    input  logic [31:0] iaddr1,
    output logic [1:0]  iwait,
    output logic [31:0] iload0,
    output logic [31:0] iload1,
    input  logic [1:0]  dREN,
    input  logic [1:0]  dWEN,
    input  logic [31:0] daddr0,
    input  logic [31:0] daddr1,
    input  logic [31:0] dstore0,
    input  logic [31:0] dstore1,
    output logic [1:0]  dwait,
    output logic [31:0] dload0,
    output logic [31:0] dload1,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        err
);
    localparam int unsigned CW = 10;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [1:0] G_D0 = 2'd0;
    localparam logic [1:0] G_D1 = 2'd1;
    localparam logic [1:0] G_I0 = 2'd2;
    localparam logic [1:0] G_I1 = 2'd3;

    logic [0:0]    state, state_n;
    logic [1:0]    gnt, gnt_n;
    logic          rr_d, rr_d_n, rr_i, rr_i_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          err_n;

    logic          busy, sel_ren, sel_wen, sel_req, done_c;
    logic [31:0]   sel_addr, sel_store;
    logic [1:0]    dreq;

    assign dreq = dREN | dWEN;
    assign busy = (state == BUSY);

    // Live request of the granted cache; a simultaneous read+write is a write.
    always_comb begin
        sel_ren   = 1'b0;
        sel_wen   = 1'b0;
        sel_addr  = '0;
        sel_store = '0;
        case (gnt)
            G_D0: begin
                sel_wen   = dWEN[0];
                sel_ren   = dREN[0] & ~dWEN[0];
                sel_addr  = daddr0;
                sel_store = dstore0;
            end
            G_D1: begin
                sel_wen   = dWEN[1];
                sel_ren   = dREN[1] & ~dWEN[1];
                sel_addr  = daddr1;
                sel_store = dstore1;
            end
            G_I0: begin
                sel_ren  = iREN[0];
                sel_addr = iaddr0;
            end
            default: begin
                sel_ren  = iREN[1];
                sel_addr = iaddr1;
            end
        endcase
    end

    assign sel_req = sel_ren | sel_wen;
    assign done_c  = busy & sel_req & ramready;

    assign ramREN   = busy & sel_ren;
    assign ramWEN   = busy & sel_wen;
    assign ramaddr  = busy ? sel_addr  : '0;
    assign ramstore = busy ? sel_store : '0;

    assign dwait[0] = ~(done_c && gnt == G_D0);
    assign dwait[1] = ~(done_c && gnt == G_D1);
    assign iwait[0] = ~(done_c && gnt == G_I0);
    assign iwait[1] = ~(done_c && gnt == G_I1);

    assign dload0 = (busy && gnt == G_D0) ? ramload : '0;
    assign dload1 = (busy && gnt == G_D1) ? ramload : '0;
    assign iload0 = (busy && gnt == G_I0) ? ramload : '0;
    assign iload1 = (busy && gnt == G_I1) ? ramload : '0;

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        rr_d_n  = rr_d;
        rr_i_n  = rr_i;
        cnt_n   = cnt;
        err_n   = err;
        case (state)
            IDLE: begin
                if (|dreq) begin
                    gnt_n   = {1'b0, (&dreq) ? rr_d : dreq[1]};
                    cnt_n   = '0;
                    state_n = BUSY;
                end else if (|iREN) begin
                    gnt_n   = {1'b1, (&iREN) ? rr_i : iREN[1]};
                    cnt_n   = '0;
                    state_n = BUSY;
                end
            end
            default: begin
                if (!sel_req) begin
                    state_n = IDLE;
                end else if (ramready) begin
                    // Completion beats a coincident timeout; favour the other core next time.
                    if (gnt[1]) rr_i_n = ~gnt[0];
                    else        rr_d_n = ~gnt[0];
                    state_n = IDLE;
                end else if (cnt >= CW'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = (cnt == '1) ? cnt : cnt + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            gnt   <= G_D0;
            rr_d  <= 1'b0;
            rr_i  <= 1'b0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            rr_d  <= rr_d_n;
            rr_i  <= rr_i_n;
            cnt   <= cnt_n;
            err   <= err_n;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions are queued at stimulus time
// and popped when a wait line drops.
module tb_mem_arbiter;
    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  iREN, dREN, dWEN, iwait, dwait;
    logic [31:0] iaddr0, iaddr1, daddr0, daddr1, dstore0, dstore1;
    logic [31:0] iload0, iload1, dload0, dload1;
    logic        ramREN, ramWEN, ramready, err;
    logic [31:0] ramaddr, ramstore, ramload, ramload_v;
    logic        use_model;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign ramload = use_model ? mem_word(ramaddr) : ramload_v;

    mem_arbiter #(.TIMEOUT(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr0(iaddr0), .iaddr1(iaddr1), .iwait(iwait),
        .iload0(iload0), .iload1(iload1),
        .dREN(dREN), .dWEN(dWEN), .daddr0(daddr0), .daddr1(daddr1),
        .dstore0(dstore0), .dstore1(dstore1), .dwait(dwait),
        .dload0(dload0), .dload1(dload1),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready), .err(err)
    );

    // Observation only: which requester completes this cycle, and its load value.
    function automatic int obs_id();
        if (dwait[0] === 1'b0) return 0;
        if (dwait[1] === 1'b0) return 1;
        if (iwait[0] === 1'b0) return 2;
        if (iwait[1] === 1'b0) return 3;
        return -1;
    endfunction

    function automatic logic [31:0] obs_load(input int id);
        case (id)
            0: return dload0;
            1: return dload1;
            2: return iload0;
            default: return iload1;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; ramready = 1'b0;
        iaddr0 = '0; iaddr1 = '0; daddr0 = '0; daddr1 = '0; dstore0 = '0; dstore1 = '0;
        ramload_v = 32'hFFFF_FFFF; use_model = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        n_cmp++;
        if ({dwait, iwait} !== 4'b1111 || ramREN !== 1'b0 || ramWEN !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: waits=%b ren=%b wen=%b err=%b, want 1111 0 0 0", {dwait, iwait}, ramREN, ramWEN, err);
        end
        n_cmp++;
        if (ramaddr !== 32'h0 || ramstore !== 32'h0 || (iload0 | iload1 | dload0 | dload1) !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: addr=%h store=%h loads_or=%h, want 0", ramaddr, ramstore, iload0 | iload1 | dload0 | dload1);
        end
        tick();
        nRST = 1'b1;
        settle();
    endtask

    task automatic test_i0_read();
        int ren_cycles = 0;
        int oid;
        exp_t e;
        use_model = 1'b0;
        ramload_v = 32'h2402_0001;
        iaddr0 = 32'h0000_0100;
        sbq.push_back('{2, 32'h2402_0001});
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            iREN = (k <= 3) ? 2'b01 : 2'b00;
            ramready = (k == 3);
            settle();
            if (ramREN === 1'b1) ren_cycles++;
            n_cmp++;
            if (ramWEN !== 1'b0 || ramstore !== 32'h0) begin
                n_bad++;
                $display("FAIL i0_wen: cycle %0d wen=%b store=%h, want 0 0", k, ramWEN, ramstore);
            end
            if (k >= 1 && k <= 3) begin
                n_cmp++;
                if (ramaddr !== 32'h100) begin
                    n_bad++;
                    $display("FAIL i0_addr: cycle %0d addr=%h, want 00000100", k, ramaddr);
                end
            end
            oid = obs_id();
            if (oid >= 0) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL i0_unexpected: completion id=%0d, nothing expected", oid);
                end else begin
                    e = sbq.pop_front();
                    if (oid !== e.id || obs_load(oid) !== e.data || k !== 3) begin
                        n_bad++;
                        $display("FAIL i0_sb: cycle %0d id=%0d data=%h, want cycle 3 id=%0d data=%h", k, oid, obs_load(oid), e.id, e.data);
                    end
                end
            end
        end
        n_cmp++;
        if (ren_cycles !== 3) begin
            n_bad++;
            $display("FAIL i0_ren_len: ramREN high %0d cycles, want 3", ren_cycles);
        end
        n_cmp++;
        if (sbq.size() !== 0) begin
            n_bad++;
            $display("FAIL i0_left: %0d completions missing, want 0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_priority();
        int oid;
        exp_t e;
        use_model = 1'b0;
        iaddr0 = 32'h300; daddr1 = 32'h200;
        sbq.push_back('{1, 32'hAAAA_0001});
        sbq.push_back('{2, 32'hBBBB_0002});
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            iREN = (k <= 3) ? 2'b01 : 2'b00;
            dREN = (k <= 1) ? 2'b10 : 2'b00;
            ramready = (k == 1 || k == 3);
            ramload_v = (k == 1) ? 32'hAAAA_0001 : 32'hBBBB_0002;
            settle();
            if (k <= 2) begin
                n_cmp++;
                if (iwait !== 2'b11) begin
                    n_bad++;
                    $display("FAIL prio_iwait: cycle %0d iwait=%b, want 11", k, iwait);
                end
            end
            if (k == 1 || k == 3) begin
                n_cmp++;
                if (ramaddr !== ((k == 1) ? 32'h200 : 32'h300) || ramREN !== 1'b1) begin
                    n_bad++;
                    $display("FAIL prio_addr: cycle %0d addr=%h ren=%b, want %h 1", k, ramaddr, ramREN, (k == 1) ? 32'h200 : 32'h300);
                end
            end
            if (k == 2) begin
                n_cmp++;
                if (ramREN !== 1'b0) begin
                    n_bad++;
                    $display("FAIL prio_turnaround: ren=%b in idle cycle, want 0", ramREN);
                end
            end
            oid = obs_id();
            if (oid >= 0) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL prio_unexpected: completion id=%0d, nothing expected", oid);
                end else begin
                    e = sbq.pop_front();
                    if (oid !== e.id || obs_load(oid) !== e.data) begin
                        n_bad++;
                        $display("FAIL prio_sb: id=%0d data=%h, want id=%0d data=%h", oid, obs_load(oid), e.id, e.data);
                    end
                end
            end
        end
        n_cmp++;
        if (sbq.size() !== 0) begin
            n_bad++;
            $display("FAIL prio_left: %0d completions missing, want 0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_round_robin();
        int oid;
        int done = 0;
        exp_t e;
        daddr0 = 32'h10; daddr1 = 32'h20;
        use_model = 1'b1;
        for (int n = 0; n < 4; n++) sbq.push_back('{n % 2, mem_word((n % 2) ? 32'h20 : 32'h10)});
        for (int k = 0; k < 20 && done < 4; k++) begin
            tick();
            dREN = 2'b11;
            ramready = 1'b1;
            settle();
            oid = obs_id();
            if (oid >= 0) begin
                done++;
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL rr_unexpected: completion id=%0d, nothing expected", oid);
                end else begin
                    e = sbq.pop_front();
                    if (oid !== e.id || obs_load(oid) !== e.data) begin
                        n_bad++;
                        $display("FAIL rr_sb: completion %0d id=%0d data=%h, want id=%0d data=%h", done, oid, obs_load(oid), e.id, e.data);
                    end
                end
            end
        end
        tick();
        dREN = 2'b00; ramready = 1'b0; use_model = 1'b0;
        settle();
        n_cmp++;
        if (sbq.size() !== 0) begin
            n_bad++;
            $display("FAIL rr_left: %0d completions missing, want 0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_write();
        tick();
        dREN = 2'b10; dWEN = 2'b10; daddr1 = 32'h40; dstore1 = 32'hDEAD_BEEF;
        ramload_v = 32'h0; ramready = 1'b0;
        settle();
        tick();
        settle();
        n_cmp++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h40 || ramstore !== 32'hDEAD_BEEF || dwait !== 2'b11) begin
            n_bad++;
            $display("FAIL wr_drive: wen=%b ren=%b addr=%h store=%h dwait=%b, want 1 0 00000040 deadbeef 11", ramWEN, ramREN, ramaddr, ramstore, dwait);
        end
        tick();
        ramready = 1'b1;
        settle();
        n_cmp++;
        if (dwait !== 2'b01 || iwait !== 2'b11) begin
            n_bad++;
            $display("FAIL wr_done: dwait=%b iwait=%b, want 01 11", dwait, iwait);
        end
        tick();
        dREN = 2'b00; dWEN = 2'b00; ramready = 1'b0;
        settle();
    endtask

    task automatic test_withdraw();
        tick();
        dREN = 2'b10; daddr1 = 32'h90; ramready = 1'b0;
        settle();
        tick();
        settle();
        n_cmp++;
        if (ramREN !== 1'b1) begin
            n_bad++;
            $display("FAIL wd_grant: ren=%b, want 1", ramREN);
        end
        tick();
        dREN = 2'b00; ramready = 1'b1;
        settle();
        n_cmp++;
        if (ramREN !== 1'b0 || dwait !== 2'b11) begin
            n_bad++;
            $display("FAIL wd_drop: ren=%b dwait=%b, want 0 11", ramREN, dwait);
        end
        tick();
        ramready = 1'b0;
        settle();
    endtask

    task automatic test_timeout();
        tick();
        dREN = 2'b01; daddr0 = 32'h80; ramready = 1'b0;
        settle();
        for (int b = 1; b <= 8; b++) begin
            tick();
            settle();
            n_cmp++;
            if (ramREN !== 1'b1 || dwait !== 2'b11 || err !== 1'b0) begin
                n_bad++;
                $display("FAIL to_busy: busy cycle %0d ren=%b dwait=%b err=%b, want 1 11 0", b, ramREN, dwait, err);
            end
        end
        tick();
        dREN = 2'b00;
        settle();
        n_cmp++;
        if (err !== 1'b1 || ramREN !== 1'b0 || dwait !== 2'b11) begin
            n_bad++;
            $display("FAIL to_abort: err=%b ren=%b dwait=%b, want 1 0 11", err, ramREN, dwait);
        end
        tick();
        iREN = 2'b10; iaddr1 = 32'h500; ramload_v = 32'h600D_0001;
        settle();
        tick();
        ramready = 1'b1;
        settle();
        n_cmp++;
        if (iwait !== 2'b01 || iload1 !== 32'h600D_0001 || ramaddr !== 32'h500) begin
            n_bad++;
            $display("FAIL to_next: iwait=%b iload1=%h addr=%h, want 01 600d0001 00000500", iwait, iload1, ramaddr);
        end
        tick();
        iREN = 2'b00; ramready = 1'b0;
        settle();
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL to_sticky: err=%b, want 1", err);
        end
    endtask

    task automatic test_reset_busy();
        int oid;
        logic [1:0] drop = 2'b00;
        exp_t e;
        // Complete an I0 read first so the instruction pointer favours core 1.
        tick();
        iREN = 2'b01; iaddr0 = 32'h700; ramload_v = 32'h1111_0000;
        settle();
        tick();
        ramready = 1'b1;
        settle();
        tick();
        iREN = 2'b00; ramready = 1'b0;
        settle();
        tick();
        iREN = 2'b10; iaddr1 = 32'h704;
        settle();
        tick();
        settle();
        tick();
        settle();
        nRST = 1'b0;
        settle();
        n_cmp++;
        if (ramREN !== 1'b0 || {dwait, iwait} !== 4'b1111 || err !== 1'b0 || ramaddr !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_busy: ren=%b waits=%b err=%b addr=%h, want 0 1111 0 0", ramREN, {dwait, iwait}, err, ramaddr);
        end
        tick();
        nRST = 1'b1; iREN = 2'b11; iaddr0 = 32'h708; use_model = 1'b1;
        settle();
        sbq.push_back('{2, mem_word(32'h708)});
        sbq.push_back('{3, mem_word(32'h704)});
        for (int k = 0; k < 12 && iREN != 2'b00; k++) begin
            tick();
            iREN = iREN & ~drop;
            drop = 2'b00;
            ramready = 1'b1;
            settle();
            oid = obs_id();
            if (oid >= 0) begin
                if (oid >= 2) drop[oid-2] = 1'b1;
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL rst_unexpected: completion id=%0d, nothing expected", oid);
                end else begin
                    e = sbq.pop_front();
                    if (oid !== e.id || obs_load(oid) !== e.data) begin
                        n_bad++;
                        $display("FAIL rst_sb: id=%0d data=%h, want id=%0d data=%h", oid, obs_load(oid), e.id, e.data);
                    end
                end
            end
        end
        tick();
        iREN = 2'b00; ramready = 1'b0; use_model = 1'b0;
        settle();
        n_cmp++;
        if (sbq.size() !== 0) begin
            n_bad++;
            $display("FAIL rst_left: %0d completions missing, want 0", sbq.size());
        end
        sbq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_i0_read();
        test_priority();
        test_round_robin();
        test_write();
        test_withdraw();
        test_timeout();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared-memory arbiter for the dual-core MIPS build. Four cache requesters contend for one single-port RAM: core 0 and core 1 icaches, and core 0 and core 1 dcaches. The block grants one requester at a time, routes its address, control and store data to RAM, and returns load data and a per-requester wait. It sits between the per-core caches and the RAM model and replaces direct cache-to-RAM wiring.

## Interface
- TIMEOUT, 1023: maximum cycles a grant may wait for ramready before it is aborted; 1..1023.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN[1:0]  in  2  per-core instruction read request.
- iaddr0, iaddr1  in  32 each  per-core instruction word address.
- iwait[1:0]  out  2  per-core instruction wait; 0 for exactly the completion cycle.
- iload0, iload1  out  32 each  instruction data; valid when the matching iwait is 0.
- dREN[1:0], dWEN[1:0]  in  2 each  per-core data read/write request.
- daddr0, daddr1, dstore0, dstore1  in  32 each  data address and store data.
- dwait[1:0]  out  2  per-core data wait; 0 for exactly the completion cycle.
- dload0, dload1  out  32 each  data load value.
- ramREN, ramWEN  out  1 each  RAM strobes.
- ramaddr, ramstore  out  32 each  RAM address and write data.
- ramload  in  32  RAM read data; valid with ramready.
- ramready  in  1  RAM access completes this cycle.
- err  out  1  sticky; set when a grant is aborted by timeout.

## Operation
- Requesters: D0, D1, I0, I1. A data request is dREN|dWEN. If dWEN and dREN are both high, the access is a write.
- States: IDLE and BUSY.
- IDLE: if any request is high, latch the winner into a registered grant, clear the timeout counter, and go to BUSY. Otherwise stay in IDLE.
- Priority: any data request beats any instruction request.
- Within a class, a 1-bit round-robin pointer (rr_d, rr_i) selects the core. The pointer selects the favoured core when both request. A lone requester wins regardless of the pointer.
- BUSY, RAM drive: ramREN, ramWEN, ramaddr and ramstore are driven combinationally from the granted requester's live inputs. For I grants, ramWEN=0 and ramstore=0.
- BUSY, completion: on ramready=1, drop the granted requester's wait to 0 that cycle. iloadN/dloadN = ramload combinationally. The class pointer then points at the other core. Next state is IDLE.
- BUSY, withdrawal: if the granted request deasserts, drop ramREN/ramWEN, assert no completion, and return to IDLE.
- BUSY, timeout: the counter increments each BUSY cycle without ramready. When it reaches TIMEOUT, set err, drop the strobes, return to IDLE, and do not complete the access. The requester's wait stays 1.
- Ungranted requesters always see wait=1. Their load outputs are 0.
- Requesters hold address, data and strobes stable while wait=1. The caches deassert or change their request in the cycle after wait=0.

## Timing
- Reset values: state IDLE, no grant, rr_d=rr_i=0 (core 0 favoured), counter 0, err 0, all waits 1, ramREN/ramWEN 0, ramaddr/ramstore 0, all loads 0.
- Grant latency: a request sampled in IDLE at edge t drives RAM from cycle t+1.
- Minimum access is 2 cycles: grant cycle, then a BUSY cycle with ramready=1.
- There is one mandatory IDLE cycle between consecutive grants. This is the turnaround where the previous requester drops its request.
- ramready is ignored in IDLE.
- Completion and timeout in the same cycle: completion wins, and err is not set.
- Reset mid-BUSY: all outputs return to reset values immediately (asynchronous). The RAM strobes drop without completion.
- Counter width: 10 bits, saturating.

## Test plan
- Single I0 read, RAM ready after 3 BUSY cycles, ramload=0x2402_0001 -> iwait[0]=0 for one cycle with iload0=0x2402_0001; ramREN=1 for exactly 3 cycles; ramWEN=0 throughout.
- I0 and D1 request in the same cycle -> D1 granted first; I0 granted after one IDLE cycle; I0 sees iwait=1 throughout D1's access.
- D0 and D1 continuously request, ramready every BUSY cycle -> grants alternate D0, D1, D0, D1; rr_d toggles after each completion.
- D1 write with dREN=dWEN=1, daddr1=0x0000_0040, dstore1=0xDEAD_BEEF -> ramWEN=1, ramREN=0, ramaddr=0x40, ramstore=0xDEAD_BEEF; dwait[1]=0 on ramready.
- TIMEOUT=8, ramready held low -> after 8 BUSY cycles err=1, strobes drop, dwait stays 1; the next request is then granted normally and err remains 1 until reset.
- nRST pulsed low in the 2nd BUSY cycle of an I1 read -> same cycle: ramREN=0, all waits=1, err=0; after release, an I1 request is granted with rr_i=0.
